// File: rtl/stopwatch_if.sv
// Button and display bundle between the stopwatch core and its board-level driver.
// The slave side is the stopwatch itself; the master side owns the buttons.
interface stopwatch_if;
  logic       IO_BTN_C;
  logic       IO_BTN_R;
  logic       IO_BTN_L;
  logic [3:0] Digit_0;
  logic [3:0] Digit_1;
  logic [3:0] Digit_2;
  logic [3:0] Digit_3;
  logic       running;
  logic       lap_active;
  logic       full;

  modport master (
    output IO_BTN_C, IO_BTN_R, IO_BTN_L,
    input  Digit_0, Digit_1, Digit_2, Digit_3, running, lap_active, full
  );

  modport slave (
    input  IO_BTN_C, IO_BTN_R, IO_BTN_L,
    output Digit_0, Digit_1, Digit_2, Digit_3, running, lap_active, full
  );
endinterface

// File: rtl/stopwatch.sv
// MM:SS stopwatch with debounced start/stop, lap and clear buttons and BCD display outputs.
// Time saturates at 59:59 (FULL); only clear leaves FULL.
module stopwatch #(
  parameter int unsigned TICK_MAX = 100000000,
  parameter int unsigned DEBOUNCE = 1000000
) (
  input logic        clk,
  input logic        rst_n,
  stopwatch_if.slave io
);

  localparam int unsigned PW = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {StIdle, StRun, StStop, StFull} state_e;

  // Button bit order: 0 = start (C), 1 = lap (R), 2 = clear (L)
  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync2_q, level_q, press_q;
  logic [DW-1:0] db_cnt_q [3];

  assign btn_raw = {io.IO_BTN_L, io.IO_BTN_R, io.IO_BTN_C};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] == level_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DW'(DEBOUNCE - 1)) begin
          // Differing level seen DEBOUNCE times in a row: accept it, pulse on rising only
          level_q[i]  <= sync2_q[i];
          press_q[i]  <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic clr_p, start_p, lap_p;
  assign clr_p   = press_q[2];
  assign start_p = press_q[0] & ~clr_p;
  assign lap_p   = press_q[1] & ~clr_p & ~press_q[0];

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   time_q, time_d;   // {min tens, min ones, sec tens, sec ones}
  logic [15:0]   lap_q, lap_d;
  logic          lap_active_q, lap_active_d;
  logic [15:0]   disp_q;
  logic          tick, at_max;

  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd9) begin
      r[3:0] = t[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (t[7:4] != 4'd5) begin
        r[7:4] = t[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (t[11:8] != 4'd9) begin
          r[11:8] = t[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = t[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign tick   = (state_q == StRun) && (presc_q == PW'(TICK_MAX - 1));
  assign at_max = (time_q == 16'h5959);

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    time_d       = time_q;
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    if (clr_p) begin
      state_d      = StIdle;
      presc_d      = '0;
      time_d       = '0;
      lap_d        = '0;
      lap_active_d = 1'b0;
    end else begin
      if (state_q == StRun) presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick && !at_max) time_d = bcd_inc(time_q);
      unique case (state_q)
        StIdle: if (start_p) state_d = StRun;
        StRun: begin
          // Saturating tick wins over a simultaneous stop so time never overshoots
          if (tick && at_max) begin
            state_d = StFull;
            presc_d = '0;
          end else if (start_p) begin
            state_d = StStop;
          end
        end
        StStop: if (start_p) state_d = StRun;
        StFull: ;
        default: state_d = StIdle;
      endcase
      if (lap_p && (state_q == StRun || state_q == StStop)) begin
        if (lap_active_q) begin
          lap_active_d = 1'b0;
        end else if (state_q == StRun) begin
          lap_d        = time_q;
          lap_active_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      time_q       <= '0;
      lap_q        <= '0;
      lap_active_q <= 1'b0;
      disp_q       <= '0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      time_q       <= time_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      disp_q       <= lap_active_q ? lap_q : time_q;
    end
  end

  assign io.Digit_0    = disp_q[3:0];
  assign io.Digit_1    = disp_q[7:4];
  assign io.Digit_2    = disp_q[11:8];
  assign io.Digit_3    = disp_q[15:12];
  assign io.running    = (state_q == StRun);
  assign io.lap_active = lap_active_q;
  assign io.full       = (state_q == StFull);

endmodule

// File: tb/tb_stopwatch.sv
// Directed bench for stopwatch with TICK_MAX=4, DEBOUNCE=2.
// A raw press reaches the FSM five edges after the input changes (2 sync, 2 debounce, 1 pulse).
module tb_stopwatch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  stopwatch_if sw_if ();

  stopwatch #(
    .TICK_MAX(4),
    .DEBOUNCE(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (sw_if)
  );

  always #5 clk = ~clk;

  logic [15:0] disp;
  assign disp = {sw_if.Digit_3, sw_if.Digit_2, sw_if.Digit_1, sw_if.Digit_0};

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: sw_if.IO_BTN_C = v;
      1: sw_if.IO_BTN_R = v;
      default: sw_if.IO_BTN_L = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    step(4);
    set_btn(b, 1'b0);
    step(6);
  endtask

  // Start C, release, then return on the first sample with running=1 (that edge is k=0)
  task automatic start_run(input string tag);
    int n;
    sw_if.IO_BTN_C = 1'b1;
    step(4);
    sw_if.IO_BTN_C = 1'b0;
    n = 0;
    while (sw_if.running !== 1'b1 && n < 50) begin
      step(1);
      n++;
    end
    check_eq(tag, 16'(sw_if.running), 16'd1);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_disp"}, disp, 16'h0000);
    check_eq({tag, "_run"}, 16'(sw_if.running), 16'd0);
    check_eq({tag, "_lap"}, 16'(sw_if.lap_active), 16'd0);
    check_eq({tag, "_full"}, 16'(sw_if.full), 16'd0);
  endtask

  int   starts;
  logic prev;

  initial begin
    sw_if.IO_BTN_C = 1'b0;
    sw_if.IO_BTN_R = 1'b0;
    sw_if.IO_BTN_L = 1'b0;
    step(2);
    check_idle("reset");
    rst_n = 1'b1;
    step(3);

    // 60 ticks -> 01:00; stop lands after the 61st tick at k=244
    start_run("t1_start");
    step(241);
    check_eq("t1_0100", disp, 16'h0100);
    check_eq("t1_run", 16'(sw_if.running), 16'd1);
    press(0);
    check_eq("t1_stop_run", 16'(sw_if.running), 16'd0);
    check_eq("t1_stop_disp", disp, 16'h0101);
    step(100);
    check_eq("t1_frozen_disp", disp, 16'h0101);
    check_eq("t1_frozen_run", 16'(sw_if.running), 16'd0);
    press(2);
    check_idle("t1_clear");

    // Bounce 1-0-1-0 then hold: exactly one start
    starts = 0;
    prev   = sw_if.running;
    for (int j = 0; j < 30; j++) begin
      sw_if.IO_BTN_C = (j >= 4) || (j % 2 == 0);
      step(1);
      if (sw_if.running && !prev) starts++;
      prev = sw_if.running;
    end
    check_eq("t2_starts", 16'(starts), 16'd1);
    check_eq("t2_run", 16'(sw_if.running), 16'd1);
    sw_if.IO_BTN_C = 1'b0;
    step(6);
    press(2);
    check_idle("t2_clear");

    // Lap at 00:05 (captured at k=22), released to live 00:08 at k=36
    start_run("t3_start");
    step(17);
    sw_if.IO_BTN_R = 1'b1;
    step(4);
    sw_if.IO_BTN_R = 1'b0;
    step(9);
    check_eq("t3_lap_disp", disp, 16'h0005);
    check_eq("t3_lap_act", 16'(sw_if.lap_active), 16'd1);
    sw_if.IO_BTN_R = 1'b1;
    step(3);
    check_eq("t3_lap_hold", disp, 16'h0005);
    step(1);
    sw_if.IO_BTN_R = 1'b0;
    step(2);
    check_eq("t3_live_disp", disp, 16'h0008);
    check_eq("t3_lap_off", 16'(sw_if.lap_active), 16'd0);
    check_eq("t3_run", 16'(sw_if.running), 16'd1);
    press(2);
    check_idle("t3_clear");

    // Saturate at 59:59 (3599 ticks), FULL at k=14400
    start_run("t4_start");
    step(14399);
    check_eq("t4_5959", disp, 16'h5959);
    check_eq("t4_not_full", 16'(sw_if.full), 16'd0);
    step(2);
    check_eq("t4_full", 16'(sw_if.full), 16'd1);
    check_eq("t4_hold_disp", disp, 16'h5959);
    check_eq("t4_run_off", 16'(sw_if.running), 16'd0);
    press(0);
    press(1);
    check_eq("t4_c_full", 16'(sw_if.full), 16'd1);
    check_eq("t4_c_disp", disp, 16'h5959);
    check_eq("t4_c_run", 16'(sw_if.running), 16'd0);
    check_eq("t4_r_lap", 16'(sw_if.lap_active), 16'd0);
    press(2);
    check_idle("t4_clear");

    // C and L together at 00:10: clear wins
    start_run("t5_start");
    step(37);
    sw_if.IO_BTN_C = 1'b1;
    sw_if.IO_BTN_L = 1'b1;
    step(4);
    sw_if.IO_BTN_C = 1'b0;
    sw_if.IO_BTN_L = 1'b0;
    step(16);
    check_idle("t5_both");
    press(1);
    check_eq("t5_idle_lap", 16'(sw_if.lap_active), 16'd0);

    // Reset at 00:30 with lap shown, C held through reset
    start_run("t6_start");
    step(100);
    sw_if.IO_BTN_R = 1'b1;
    step(4);
    sw_if.IO_BTN_R = 1'b0;
    step(17);
    check_eq("t6_lap_disp", disp, 16'h0026);
    check_eq("t6_lap_act", 16'(sw_if.lap_active), 16'd1);
    sw_if.IO_BTN_C = 1'b1;
    rst_n = 1'b0;
    step(1);
    check_idle("t6_rst");
    rst_n = 1'b1;
    step(4);
    check_eq("t6_no_early_start", 16'(sw_if.running), 16'd0);
    step(1);
    check_eq("t6_start_after_db", 16'(sw_if.running), 16'd1);
    sw_if.IO_BTN_C = 1'b0;
    step(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
